loop_iter_gen: RTL and testbench
================================

# loop_iter_gen

Nested-loop iteration sequencer that produces the `iter_done` step/wrap vector, plus start and stall, consumed by the memory address walkers.
- Software programs per-loop iteration counts from the instruction decoder, outermost loop first.
- A `start` pulse walks the full loop nest, one innermost step per un-stalled cycle.
- Wrap bits cascade outward; bit 0 flags completion of the whole nest.

## Interface
- `LOOP_ID_W`, 5, width of the loop index.
- `NUM_MAX_LOOPS`, `1 << LOOP_ID_W`, number of loop levels; index 0 is outermost, `NUM_MAX_LOOPS-1` is innermost.
- `ITER_W`, 16, width of an iteration count.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cfg_loop_iter_v` in 1: write `cfg_loop_iter` into the table slot at the write pointer.
- `cfg_loop_iter` in `ITER_W`: iteration count; a value of 0 is treated as 1.
- `block_done` in 1: end of instruction block.
  - Clears the write pointer and sets all counts to 1.
  - Aborts a running walk.
- `start` in 1: single-cycle pulse that begins a walk.
- `stall` in 1: when high, this cycle produces no step.
- `iter_done` out `NUM_MAX_LOOPS+1`:
  - bit `NUM_MAX_LOOPS` = step.
  - bit i (0..`NUM_MAX_LOOPS-1`) = loop i wraps this step.
  - bit 0 = nest complete.
- `busy` out 1: high in RUN.
- `done` out 1: registered one-cycle pulse, the cycle after `iter_done[0]`.

## Operation
- **Table:** `NUM_MAX_LOOPS` counts of `ITER_W` bits each, reset to 1.
  - The write pointer resets to 0 and increments on each accepted write.
  - The pointer saturates at `NUM_MAX_LOOPS`; writes at saturation are ignored.
  - Writes while `busy` are ignored and do not move the pointer.
  - Unwritten loops keep count 1 and wrap on every step.
- **Counters:** `cnt[i]` is `ITER_W` bits. `last[i]` = count−1, with count 0 giving `last[i]` 0.
- **FSM states:**
  - IDLE: `busy`=0. `start` → RUN and clears all `cnt`.
  - RUN: `busy`=1. `iter_done[0]` → IDLE. `block_done` → IDLE (abort, no `done`).
- **`iter_done` decode (combinational from state, `cnt`, `stall`):**
  - `step` = RUN & ~`stall`.
  - `iter_done[NUM_MAX_LOOPS]` = `step`.
  - `iter_done[i]` = `step` & (`cnt[j]==last[j]` for all j ≥ i).
  - In IDLE, all bits are 0.
- **Counter update on each `step`:**
  - If `iter_done[i]`: `cnt[i]` ← 0.
  - Else if `iter_done[i+1]`: `cnt[i]` ← `cnt[i]`+1.
  - Otherwise `cnt[i]` holds. With `stall` high, all `cnt` hold.
- **Steps per walk:** product of all counts. `iter_done[0]` asserts on the final step.
- **Simultaneous events:**
  - `block_done` and `start` together: `block_done` wins and `start` is ignored.
  - `start` while RUN: ignored.
  - `block_done` and `cfg_loop_iter_v` together: the clear wins.
- **Reset mid-walk:** state → IDLE, all `cnt`=0, table=1, pointer=0, `done`=0. No `iter_done` bits assert in the reset cycle.

## Timing
- `start` is sampled at edge T. RUN begins at cycle T+1, so the first `iter_done[NUM_MAX_LOOPS]` can appear in T+1.
- `iter_done` has a combinational path from `stall` (same-cycle gating), matching how the walkers consume `stall`.
- `done` is high for exactly one cycle, the cycle after the final step. `busy` falls in that same cycle.
- A table write in cycle T is visible to a `start` sampled at T+1 or later.
- Reset values: `iter_done`=0, `busy`=0, `done`=0, `stall_cycles`=0.

## Configuration
- Macro `LOOP_ITER_STALL_CNT_EN`.
- Defined: adds output `stall_cycles` out 32.
  - Counts RUN cycles with `stall` high.
  - Cleared to 0 on an accepted `start` and on `reset`.
  - Saturates at 2^32−1.
  - The value holds after the walk ends.
- Undefined: port and counter are absent. All other behaviour is identical.

## Test plan
- `LOOP_ID_W`=2. Write counts 2,3 (loops 2,3 left at 1), then pulse `start`, no stall.
  - Step bit high for 6 consecutive cycles.
  - `iter_done[1]` on steps 3 and 6; `iter_done[2]` and `iter_done[3]` on every step.
  - `iter_done[0]` on step 6 only; `done` pulses one cycle later; `busy` high for 6 cycles.
- Same config, `stall` high on steps 2–4 for 3 cycles.
  - `iter_done` is all-zero during the stall and counters hold.
  - Completion comes 3 cycles later than the un-stalled run.
  - `stall_cycles`=3 when the macro is defined.
- Write count 0 to loop 0, leave the rest at default, then `start`.
  - Exactly 1 step, with `iter_done[0]` asserted on it.
- Write 5 counts with `LOOP_ID_W`=2.
  - The 5th write is ignored and the pointer stays saturated at 4.
  - `block_done` then resets the pointer; the next write lands in loop 0.
- `block_done` at step 3 of a 6-step walk.
  - `busy` drops next cycle, with no `iter_done[0]` and no `done`.
  - A subsequent `start` runs 1 step, since all counts are back to 1.
- `reset` asserted mid-walk, with `start` in the same cycle.
  - All outputs are 0 the next cycle and the FSM is in IDLE.

Source files
------------

// File: rtl/loop_iter_gen.sv
// Nested-loop iteration sequencer: walks a programmed loop nest one innermost step per
// un-stalled cycle. Define LOOP_ITER_STALL_CNT_EN to add the stall_cycles counter output.
module loop_iter_gen #(
  parameter int LOOP_ID_W     = 5,
  parameter int NUM_MAX_LOOPS = 1 << LOOP_ID_W,
  parameter int ITER_W        = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_loop_iter_v,
  input  logic [ITER_W-1:0]        cfg_loop_iter,
  input  logic                     block_done,
  input  logic                     start,
  input  logic                     stall,
  output logic [NUM_MAX_LOOPS:0]   iter_done,
  output logic                     busy,
`ifdef LOOP_ITER_STALL_CNT_EN
  output logic [31:0]              stall_cycles,
`endif
  output logic                     done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [LOOP_ID_W:0] PTR_MAX = (LOOP_ID_W + 1)'(NUM_MAX_LOOPS);

  state_t                state_q, state_d;
  logic [LOOP_ID_W:0]    wr_ptr;
  logic [ITER_W-1:0]     tbl  [NUM_MAX_LOOPS];
  logic [ITER_W-1:0]     last [NUM_MAX_LOOPS];
  logic [ITER_W-1:0]     cnt  [NUM_MAX_LOOPS];
  logic                  step;
  logic                  start_ok;

  assign busy     = (state_q == RUN);
  assign start_ok = (state_q == IDLE) && start && !block_done;
  // Reset is folded in so no step or wrap is visible while reset is held.
  assign step     = (state_q == RUN) && !stall && !reset;

  // A programmed count of 0 behaves as 1, so its last index is 0 either way.
  always_comb begin
    for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
      last[i] = (tbl[i] == '0) ? '0 : tbl[i] - ITER_W'(1);
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves
  // a value unassigned and infers a latch.
  always_comb begin
    logic wrap;
    state_d   = state_q;
    iter_done = '0;
    wrap      = step;
    iter_done[NUM_MAX_LOOPS] = step;
    for (int i = NUM_MAX_LOOPS - 1; i >= 0; i--) begin
      wrap         = wrap && (cnt[i] == last[i]);
      iter_done[i] = wrap;
    end
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (block_done || iter_done[0]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= iter_done[0] && !block_done;
    end
  end

  // NOTE: the table and counters are small register arrays that must come out of reset
  // holding defined counts, so they are reset explicitly rather than mapped to RAM.
  always_ff @(posedge clk) begin
    if (reset || block_done) begin
      wr_ptr <= '0;
      for (int i = 0; i < NUM_MAX_LOOPS; i++) tbl[i] <= ITER_W'(1);
    end else if (cfg_loop_iter_v && !busy && wr_ptr != PTR_MAX) begin
      tbl[wr_ptr[LOOP_ID_W-1:0]] <= cfg_loop_iter;
      wr_ptr                     <= wr_ptr + (LOOP_ID_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      for (int i = 0; i < NUM_MAX_LOOPS; i++) cnt[i] <= '0;
    end else if (step) begin
      for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
        if (iter_done[i])          cnt[i] <= '0;
        else if (iter_done[i + 1]) cnt[i] <= cnt[i] + ITER_W'(1);
      end
    end
  end

`ifdef LOOP_ITER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      stall_cycles <= '0;
    end else if (busy && stall && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_loop_iter_gen.sv
// Directed bench for loop_iter_gen with a 4-level nest; checks stall_cycles only when
// LOOP_ITER_STALL_CNT_EN is defined.
module tb_loop_iter_gen;

  localparam int LW = 2;
  localparam int NL = 1 << LW;

  logic          clk = 1'b0;
  logic          reset, cfg_loop_iter_v, block_done, start, stall;
  logic [15:0]   cfg_loop_iter;
  logic [NL:0]   iter_done;
  logic          busy, done;
`ifdef LOOP_ITER_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  int tests = 0;
  int fails = 0;

  loop_iter_gen #(.LOOP_ID_W(LW), .ITER_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_loop_iter_v (cfg_loop_iter_v),
    .cfg_loop_iter   (cfg_loop_iter),
    .block_done      (block_done),
    .start           (start),
    .stall           (stall),
    .iter_done       (iter_done),
    .busy            (busy),
`ifdef LOOP_ITER_STALL_CNT_EN
    .stall_cycles    (stall_cycles),
`endif
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] val);
    cfg_loop_iter_v = 1'b1;
    cfg_loop_iter   = val;
    step_clk();
    cfg_loop_iter_v = 1'b0;
  endtask

  task automatic pulse_block_done();
    block_done = 1'b1;
    step_clk();
    block_done = 1'b0;
  endtask

  // Hand-derived pattern for counts {2,3,1,1}: loop 1 wraps every third step.
  function automatic logic [NL:0] exp_23(input int s);
    logic [NL:0] v;
    v = 5'b11100;
    if (s % 3 == 0) v = v | 5'b00010;
    if (s == 6)     v = v | 5'b00001;
    return v;
  endfunction

  task automatic run_walk(output int steps, output bit finished);
    steps    = 0;
    finished = 1'b0;
    start    = 1'b1;
    step_clk();
    start    = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (iter_done[NL]) steps++;
      if (iter_done[0]) begin
        finished = 1'b1;
        step_clk();
        break;
      end
      step_clk();
    end
  endtask

  int  n_steps;
  bit  fin;

  initial begin
    reset = 1'b1; cfg_loop_iter_v = 1'b0; cfg_loop_iter = '0;
    block_done = 1'b0; start = 1'b0; stall = 1'b0;
    step_clk();
    step_clk();
    reset = 1'b0;
    #1;
    check("rst_iter_done", iter_done, '0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef LOOP_ITER_STALL_CNT_EN
    check("rst_stall_cycles", stall_cycles, 0);
`endif

    // Counts 2,3 then an un-stalled walk of 6 steps.
    wr(16'd2);
    wr(16'd3);
    start = 1'b1;
    step_clk();
    start = 1'b0;
    for (int s = 1; s <= 6; s++) begin
      #1;
      check($sformatf("run_iter_done_s%0d", s), iter_done, exp_23(s));
      check($sformatf("run_busy_s%0d", s), busy, 1);
      check($sformatf("run_done_s%0d", s), done, 0);
      step_clk();
    end
    #1;
    check("run_done_pulse", done, 1);
    check("run_busy_fall", busy, 0);
    check("run_idle_iter_done", iter_done, '0);
    step_clk();
    check("run_done_one_cycle", done, 0);

    // Same table, stall for three cycles after step 1.
    start = 1'b1;
    step_clk();
    start = 1'b0;
    #1;
    check("stall_s1", iter_done, exp_23(1));
    step_clk();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall_zero_%0d", k), iter_done, '0);
      check($sformatf("stall_busy_%0d", k), busy, 1);
      step_clk();
    end
    stall = 1'b0;
    for (int s = 2; s <= 6; s++) begin
      #1;
      check($sformatf("stall_iter_done_s%0d", s), iter_done, exp_23(s));
      step_clk();
    end
    #1;
    check("stall_done_pulse", done, 1);
    check("stall_busy_fall", busy, 0);
`ifdef LOOP_ITER_STALL_CNT_EN
    check("stall_cycles_3", stall_cycles, 3);
`endif
    step_clk();

    // Count 0 on loop 0 with everything else default: a single completing step.
    pulse_block_done();
    wr(16'd0);
    start = 1'b1;
    step_clk();
    start = 1'b0;
    #1;
    check("zero_count_iter_done", iter_done, 5'b11111);
    step_clk();
    check("zero_count_done", done, 1);
    check("zero_count_busy", busy, 0);

    // Five writes with four slots: last write dropped, walk is 2*2*1*1 = 4 steps.
    pulse_block_done();
    wr(16'd2); wr(16'd2); wr(16'd1); wr(16'd1); wr(16'd3);
    run_walk(n_steps, fin);
    check("sat_finished", fin, 1);
    check("sat_steps", n_steps, 4);
    check("sat_done", done, 1);
    // block_done resets the pointer; next write goes to loop 0 -> 3 steps.
    pulse_block_done();
    wr(16'd3);
    run_walk(n_steps, fin);
    check("ptr_clr_finished", fin, 1);
    check("ptr_clr_steps", n_steps, 3);

    // Abort a 6-step walk at step 3.
    pulse_block_done();
    wr(16'd2);
    wr(16'd3);
    start = 1'b1;
    step_clk();
    start = 1'b0;
    for (int s = 1; s <= 2; s++) begin
      #1;
      check($sformatf("abort_s%0d", s), iter_done, exp_23(s));
      step_clk();
    end
    block_done = 1'b1;
    #1;
    check("abort_s3", iter_done, exp_23(3));
    step_clk();
    block_done = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_no_done", done, 0);
    check("abort_iter_done", iter_done, '0);
    step_clk();
    check("abort_no_done_late", done, 0);
    run_walk(n_steps, fin);
    check("abort_rerun_finished", fin, 1);
    check("abort_rerun_steps", n_steps, 1);

    // Reset mid-walk with start in the same cycle.
    wr(16'd2);
    wr(16'd3);
    stall = 1'b1;
    start = 1'b1;
    step_clk();
    start = 1'b0;
    stall = 1'b0;
    step_clk();
    reset = 1'b1;
    start = 1'b1;
    #1;
    check("rst_mid_cycle_iter_done", iter_done, '0);
    step_clk();
    reset = 1'b0;
    start = 1'b0;
    #1;
    check("rst_mid_iter_done", iter_done, '0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
`ifdef LOOP_ITER_STALL_CNT_EN
    check("rst_mid_stall_cycles", stall_cycles, 0);
`endif
    step_clk();
    check("rst_mid_still_idle", busy, 0);
    run_walk(n_steps, fin);
    check("rst_mid_table_default", n_steps, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
